// File: rtl/mem_unit_pkg.sv
// Shared definitions for the memory-access stage: op encodings, constants,
// FSM state type and small op-decoding helpers.
package mem_unit_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NopRegAddr   = 5'd0;
    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LAST,
        ST_DONE
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Index of the final byte of the transfer (N-1)
    function automatic logic [1:0] last_index(input logic [3:0] op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
            MEM_LW, MEM_SW:          return 2'd3;
            default:                 return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_unit_load_ext.sv
// Load result extension: picks the loaded width out of the little-endian
// byte buffer and sign- or zero-extends it to 32 bits.
module mem_load_ext
    import mem_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] data,
    output logic [31:0] result
);

    // Width selection and extension by load op
    always_comb begin
        result = ZeroWord;
        case (op)
            MEM_LB:  result = {{24{data[7]}}, data[7:0]};
            MEM_LBU: result = {24'h000000, data[7:0]};
            MEM_LH:  result = {{16{data[15]}}, data[15:0]};
            MEM_LHU: result = {16'h0000, data[15:0]};
            MEM_LW:  result = data;
            default: result = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// RV32I memory-access stage: byte-serial loads/stores over an 8-bit RAM
// port with pipeline stall, plus pass-through of non-memory results.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_mem_op,
    input  logic [31:0]       ex_mem_addr,
    input  logic [31:0]       ex_store_data,
    input  logic              ram_gnt,
    input  logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    output logic              ram_req,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              stall_req
);

    mem_state_t        state, state_nxt;
    logic [1:0]        idx;
    logic [1:0]        pend_idx;
    logic              pending;
    logic [31:0]       byte_buf;
    logic [31:0]       load_result;

    logic              op_load, op_store, op_mem;
    logic              issue_phase, issue, last_issue;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        cur_store_byte;
    logic              unused_addr_hi;

    assign op_load        = is_load(ex_mem_op);
    assign op_store       = is_store(ex_mem_op);
    assign op_mem         = op_load | op_store;
    assign issue_phase    = ((state == ST_IDLE) && op_mem) || (state == ST_ACCESS);
    assign issue          = issue_phase && ram_gnt;
    assign last_issue     = issue && (idx == last_index(ex_mem_op));
    assign cur_addr       = ex_mem_addr[ADDR_W-1:0] + ADDR_W'(idx);
    assign cur_store_byte = ex_store_data[{idx, 3'b000} +: 8];
    assign unused_addr_hi = ^ex_mem_addr[31:ADDR_W];

    mem_load_ext u_load_ext (
        .op     (ex_mem_op),
        .data   (byte_buf),
        .result (load_result)
    );

    // State, byte index, pending-capture flag and load buffer
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            pend_idx <= 2'd0;
            pending  <= 1'b0;
            byte_buf <= ZeroWord;
        end else begin
            state   <= state_nxt;
            pending <= issue && op_load;
            if (issue) begin
                pend_idx <= idx;
                idx      <= last_issue ? 2'd0 : idx + 2'd1;
            end
            if (pending) begin
                byte_buf[{pend_idx, 3'b000} +: 8] <= ram_dout;
            end
        end
    end

    // Next-state and all outputs; everything forced to 0 while in reset
    always_comb begin
        state_nxt = state;
        ram_addr  = '0;
        ram_wr    = 1'b0;
        ram_din   = 8'h00;
        ram_req   = 1'b0;
        mem_wd    = NopRegAddr;
        mem_wreg  = WriteDisable;
        mem_wdata = ZeroWord;
        stall_req = 1'b0;
        if (rst != RstEnable) begin
            case (state)
                ST_IDLE, ST_ACCESS: begin
                    if (state == ST_IDLE && !op_mem) begin
                        mem_wd    = ex_wd;
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end else begin
                        ram_req   = 1'b1;
                        stall_req = 1'b1;
                        ram_addr  = cur_addr;
                        mem_wd    = ex_wd;
                        if (op_store && ram_gnt) begin
                            ram_wr  = 1'b1;
                            ram_din = cur_store_byte;
                        end
                        if (last_issue) begin
                            state_nxt = op_load ? ST_LAST : ST_DONE;
                        end else begin
                            state_nxt = ST_ACCESS;
                        end
                    end
                end
                ST_LAST: begin
                    stall_req = 1'b1;
                    mem_wd    = ex_wd;
                    state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    mem_wd    = ex_wd;
                    mem_wreg  = op_load ? ex_wreg : WriteDisable;
                    mem_wdata = op_load ? load_result : ZeroWord;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_unit.md
# mem_unit

Memory-access stage of the RV32I pipeline. It sits between the EX/MEM register and `mem_wb`, and is the producer of the `mem_wd`/`mem_wreg`/`mem_wdata` triple that `mem_wb` latches for regfile write-back. Loads and stores run as multi-cycle transfers over the 8-bit RAM port, and the stage holds the pipeline with `stall_req` until the full access completes. Non-memory instructions pass straight through with no added cycles.

## Interface
- `ADDR_W`, 17, width of the RAM byte address.
- `clk`  in  1  clock; everything updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `ex_wd`  in  5  destination register address.
- `ex_wreg`  in  1  register write enable.
- `ex_wdata`  in  32  ALU result, used for non-memory ops.
- `ex_mem_op`  in  4  `MEM_NONE`, `MEM_LB`, `MEM_LH`, `MEM_LW`, `MEM_LBU`, `MEM_LHU`, `MEM_SB`, `MEM_SH`, `MEM_SW`.
- `ex_mem_addr`  in  32  effective byte address.
- `ex_store_data`  in  32  rs2 value for stores.
- `ram_gnt`  in  1  arbiter grants the RAM port this cycle.
- `ram_dout`  in  8  read byte; valid one cycle after the address is issued.
- `ram_addr`  out  ADDR_W  byte address.
- `ram_wr`  out  1  1 = write `ram_din`, 0 = read.
- `ram_din`  out  8  write byte.
- `ram_req`  out  1  the stage wants the RAM port.
- `mem_wd`  out  5  to `mem_wb`.
- `mem_wreg`  out  1  to `mem_wb`.
- `mem_wdata`  out  32  to `mem_wb`.
- `stall_req`  out  1  hold the IF through EX/MEM stages.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: one byte is issued per granted cycle.
  - LAST: the final load byte is captured.
  - DONE: the result is presented for one cycle.
- Byte count N: 1 for B, 2 for H, 4 for W.
- Byte k goes to address `(ex_mem_addr + k) mod 2^ADDR_W`. Addresses are truncated, have no alignment requirement, and wrap at the top of memory.
- Byte order is little-endian: byte k maps to bits `[8k+7:8k]`.
- `MEM_NONE`: combinational pass-through (`mem_* = ex_*`), `stall_req` = 0, `ram_req` = 0, FSM stays in IDLE.
- Memory op in IDLE or ACCESS:
  - `ram_req` = 1 and `stall_req` = 1.
  - `ram_addr` = address of the current byte index.
  - On a granted cycle, byte k is issued and the index advances.
  - On an ungranted cycle, the index holds and nothing is written.
- Loads:
  - A pending flag is set for every granted read; `ram_dout` is captured into the byte buffer on the following cycle only when that flag is set.
  - After the last issue the FSM enters LAST and captures the final byte, then goes to DONE.
- Stores:
  - `ram_wr` = 1 and `ram_din` = `ex_store_data[8k+7:8k]`, valid only on granted cycles.
  - After the last byte is issued the FSM goes straight to DONE.
- DONE:
  - `stall_req` = 0 and `ram_req` = 0.
  - `mem_wdata` = assembled result: LB/LH sign-extended from bit 7/15, LBU/LHU zero-extended.
  - `mem_wreg` = `ex_wreg` for loads, 0 for stores.
  - Next state is IDLE, on the same edge that `mem_wb` latches the result and EX/MEM loads the next instruction.
- While an access is in progress (not DONE), `mem_wreg` = 0.
- The EX/MEM inputs are required to stay stable while `stall_req` = 1; the stage does not re-sample them mid-access.

## Timing
- Reset: FSM → IDLE, index = 0, pending = 0, buffer = 0.
  - While `rst` = 1, every output is 0: `mem_wd`, `mem_wreg`, `mem_wdata`, `stall_req`, `ram_req`, `ram_wr`, `ram_din`, `ram_addr`.
- Reset mid-access abandons the transfer: no further writes are issued and the pending capture is dropped.
- With `ram_gnt` held at 1, counting from cycle 0 (the first cycle the op is presented):
  - Loads: `stall_req` = 1 for cycles 0..N, result in cycle N+1. LW gives a 6-cycle occupancy.
  - Stores: `stall_req` = 1 for cycles 0..N-1, DONE in cycle N.
- Each ungranted cycle adds one cycle of latency.
- `ram_gnt` may drop between a load issue and its capture; the capture still occurs.
- `stall_req` and the pass-through outputs are combinational from state and inputs. All state updates on the `clk` edge.

## Structure
- Shared defines header: the `MEM_*` op encodings, `ZeroWord`, `NopRegAddr`, `RstEnable`, `WriteDisable`.
- One sub-module, `mem_load_ext`: combinational extension of the 4-byte buffer according to op. It is reusable by any later load/store unit.
- The FSM, byte index, pending flag and buffer all live in `mem_unit`.

## Test plan
- ALU op (`ex_wd`=5, `ex_wreg`=1, `ex_wdata`=0x1234) → same cycle: `mem_wdata`=0x1234, `stall_req`=0, `ram_req`=0.
- LW at 0x100, RAM bytes 0x100..0x103 = 0x78,0x56,0x34,0x12, `ram_gnt`=1 → addresses 0x100–0x103 on cycles 0–3; cycle 5: `mem_wdata`=0x12345678, `mem_wreg`=1, `stall_req`=0.
- LB of 0x80 → 0xFFFFFF80; LBU of 0x80 → 0x00000080; LH of bytes 0x00,0x90 → 0xFFFF9000.
- SH of 0xAABBCCDD at address 0x1FFFF (ADDR_W=17), `ram_gnt` toggling 1,0,1 → writes 0xDD@0x1FFFF then 0xCC@0x00000; no write in the ungranted cycle; DONE with `mem_wreg`=0.
- `rst` asserted on cycle 2 of an SW → no writes from cycle 2 on; all outputs 0; next op restarts at byte 0.
- Back-to-back LW then ALU op → the ALU result appears the cycle after the LW's DONE, with no extra bubble.
